// File: rtl/vp_key_event_queue.sv
// Input-event front end for vp_keymap: merges PS/2 key events and gamepad numpad
// buttons into a FIFO and delivers them as paced {released, ascii} strobes.
module vp_key_event_queue #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GAP_CYCLES = 1024,
    parameter int unsigned GAP_W      = 11
) (
    input  logic        clk_i,
    input  logic        res_n_i,
    input  logic [10:0] ps2_key_i,
    input  logic [9:0]  joy_numpad_i,
    output logic        rx_data_ready_o,
    output logic [7:0]  rx_ascii_o,
    output logic        rx_released_o,
    output logic        overflow_o,
    output logic        fifo_empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE  = 1;
    localparam logic [GAP_W-1:0] GAP_ONE  = 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_GAP} state_t;

    // Returns {mapped, ascii}; unmapped codes come back with mapped=0.
    function automatic logic [8:0] xlate(input logic [7:0] sc);
        logic [8:0] r;
        case (sc)
            8'h16: r = {1'b1, 8'h31};  8'h1E: r = {1'b1, 8'h32};
            8'h26: r = {1'b1, 8'h33};  8'h25: r = {1'b1, 8'h34};
            8'h2E: r = {1'b1, 8'h35};  8'h36: r = {1'b1, 8'h36};
            8'h3D: r = {1'b1, 8'h37};  8'h3E: r = {1'b1, 8'h38};
            8'h46: r = {1'b1, 8'h39};  8'h45: r = {1'b1, 8'h30};
            8'h1C: r = {1'b1, 8'h61};  8'h32: r = {1'b1, 8'h62};
            8'h21: r = {1'b1, 8'h63};  8'h23: r = {1'b1, 8'h64};
            8'h24: r = {1'b1, 8'h65};  8'h2B: r = {1'b1, 8'h66};
            8'h34: r = {1'b1, 8'h67};  8'h33: r = {1'b1, 8'h68};
            8'h43: r = {1'b1, 8'h69};  8'h3B: r = {1'b1, 8'h6A};
            8'h42: r = {1'b1, 8'h6B};  8'h4B: r = {1'b1, 8'h6C};
            8'h3A: r = {1'b1, 8'h6D};  8'h31: r = {1'b1, 8'h6E};
            8'h44: r = {1'b1, 8'h6F};  8'h4D: r = {1'b1, 8'h70};
            8'h15: r = {1'b1, 8'h71};  8'h2D: r = {1'b1, 8'h72};
            8'h1B: r = {1'b1, 8'h73};  8'h2C: r = {1'b1, 8'h74};
            8'h3C: r = {1'b1, 8'h75};  8'h2A: r = {1'b1, 8'h76};
            8'h1D: r = {1'b1, 8'h77};  8'h22: r = {1'b1, 8'h78};
            8'h35: r = {1'b1, 8'h79};  8'h1A: r = {1'b1, 8'h7A};
            8'h29: r = {1'b1, 8'h20};  8'h79: r = {1'b1, 8'h2B};
            8'h7B: r = {1'b1, 8'h2D};  8'h7C: r = {1'b1, 8'h2A};
            8'h4A: r = {1'b1, 8'h2F};  8'h55: r = {1'b1, 8'h3D};
            8'h1F: r = {1'b1, 8'h11};  8'h27: r = {1'b1, 8'h12};
            8'h5A: r = {1'b1, 8'h0A};  8'h66: r = {1'b1, 8'h08};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Extended-key flag carries no meaning for this translation.
    logic ext_unused;
    assign ext_unused = ps2_key_i[8];

    logic [9:0]       ps2_in_q, ps2_in_d;
    logic             tog_q, tog_d, primed_q, primed_d;
    logic             st_vld_q, st_vld_d;
    logic [8:0]       st_data_q, st_data_d;
    logic [9:0]       joy_in_q, joy_in_d, joy_state_q, joy_state_d;
    logic [8:0]       mem_q [DEPTH];
    logic [8:0]       mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             empty_q, empty_d, ovf_q, ovf_d;
    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       ascii_q, ascii_d;
    logic             rel_q, rel_d;

    logic       ps2_ev, empty, full, pop, room, ps2_push, joy_push, joy_hit;
    logic [8:0] map_r, push_data, head;
    logic [9:0] joy_diff;
    logic [3:0] joy_k;

    always_comb begin
        ps2_in_d    = {ps2_key_i[10:9], ps2_key_i[7:0]};
        primed_d    = 1'b1;
        // First sample after reset seeds the history so no phantom event appears.
        tog_d       = primed_q ? ps2_in_q[9] : ps2_key_i[10];
        ps2_ev      = primed_q && (ps2_in_q[9] != tog_q);
        map_r       = xlate(ps2_in_q[7:0]);
        st_vld_d    = ps2_ev && map_r[8];
        st_data_d   = {~ps2_in_q[8], map_r[7:0]};

        empty       = (wr_ptr_q == rd_ptr_q);
        full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop         = (state_q == S_IDLE) && !empty;
        room        = !full || pop;
        head        = mem_q[rd_ptr_q[AW-1:0]];

        ps2_push    = st_vld_q && room;
        ovf_d       = ovf_q | (st_vld_q & ~room);

        joy_in_d    = joy_numpad_i;
        joy_diff    = joy_in_q ^ joy_state_q;
        joy_hit     = 1'b0;
        joy_k       = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (joy_diff[i] && !joy_hit) begin
                joy_hit = 1'b1;
                joy_k   = 4'(i);
            end
        end
        joy_push    = joy_hit && !st_vld_q && room;
        joy_state_d = joy_push ? (joy_state_q ^ (10'd1 << joy_k)) : joy_state_q;

        push_data   = ps2_push ? st_data_q
                    : {~joy_in_q[joy_k], (joy_k == 4'd9) ? 8'h30 : (8'h31 + {4'h0, joy_k})};

        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (ps2_push || joy_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        empty_d     = (wr_ptr_d == rd_ptr_d);

        state_d     = state_q;
        gap_d       = gap_q;
        ascii_d     = ascii_q;
        rel_d       = rel_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_STROBE;
                    ascii_d = head[7:0];
                    rel_d   = head[8];
                end
            end
            S_STROBE: begin
                state_d = S_GAP;
                gap_d   = GAP_LOAD;
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - GAP_ONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            ps2_in_q    <= '0;
            tog_q       <= 1'b0;
            primed_q    <= 1'b0;
            st_vld_q    <= 1'b0;
            st_data_q   <= '0;
            joy_in_q    <= '0;
            joy_state_q <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            empty_q     <= 1'b1;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
            gap_q       <= '0;
            ascii_q     <= '0;
            rel_q       <= 1'b0;
        end else begin
            ps2_in_q    <= ps2_in_d;
            tog_q       <= tog_d;
            primed_q    <= primed_d;
            st_vld_q    <= st_vld_d;
            st_data_q   <= st_data_d;
            joy_in_q    <= joy_in_d;
            joy_state_q <= joy_state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            empty_q     <= empty_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            gap_q       <= gap_d;
            ascii_q     <= ascii_d;
            rel_q       <= rel_d;
        end
    end

    assign rx_data_ready_o = (state_q == S_STROBE);
    assign rx_ascii_o      = ascii_q;
    assign rx_released_o   = rel_q;
    assign overflow_o      = ovf_q;
    assign fifo_empty_o    = empty_q;

endmodule

// File: tb/tb_vp_key_event_queue.sv
// Bench for vp_key_event_queue: queue-based event model compared every cycle,
// plus directed scenarios with hand-computed strobe sequences and timing.
module tb_vp_key_event_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned GAP   = 1024;
    localparam int unsigned GAP_W = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [9:0]  joy = '0;
    logic        rdy, rel, ovf, empty;
    logic [7:0]  ascii;

    vp_key_event_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .GAP_W(GAP_W)) dut (
        .clk_i(clk), .res_n_i(rst_n), .ps2_key_i(ps2_key), .joy_numpad_i(joy),
        .rx_data_ready_o(rdy), .rx_ascii_o(ascii), .rx_released_o(rel),
        .overflow_o(ovf), .fifo_empty_o(empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scancode table as a plain lookup: returns -1 for codes with no character.
    function automatic int key_ascii(input logic [7:0] sc);
        case (sc)
            8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33; 8'h25: return 8'h34;
            8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37; 8'h3E: return 8'h38;
            8'h46: return 8'h39; 8'h45: return 8'h30;
            8'h1C: return "a"; 8'h32: return "b"; 8'h21: return "c"; 8'h23: return "d";
            8'h24: return "e"; 8'h2B: return "f"; 8'h34: return "g"; 8'h33: return "h";
            8'h43: return "i"; 8'h3B: return "j"; 8'h42: return "k"; 8'h4B: return "l";
            8'h3A: return "m"; 8'h31: return "n"; 8'h44: return "o"; 8'h4D: return "p";
            8'h15: return "q"; 8'h2D: return "r"; 8'h1B: return "s"; 8'h2C: return "t";
            8'h3C: return "u"; 8'h2A: return "v"; 8'h1D: return "w"; 8'h22: return "x";
            8'h35: return "y"; 8'h1A: return "z";
            8'h29: return " "; 8'h79: return "+"; 8'h7B: return "-"; 8'h7C: return "*";
            8'h4A: return "/"; 8'h55: return "="; 8'h1F: return 8'h11; 8'h27: return 8'h12;
            8'h5A: return 8'h0A; 8'h66: return 8'h08;
            default: return -1;
        endcase
    endfunction

    // Model: queued entries, a two-deep delay line for keyboard events and the
    // earliest edge at which the next strobe may start.
    logic [8:0]  mq[$];
    logic        m_primed, m_last, d1v, d2v;
    logic [8:0]  d1, d2;
    logic [9:0]  m_joy_in, m_joy_st;
    int          m_next_pop;
    logic        m_rdy, m_rel, m_ovf, m_empty;
    logic [7:0]  m_ascii;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_primed = 1'b0; m_last = 1'b0; d1v = 1'b0; d2v = 1'b0; d1 = '0; d2 = '0;
            m_joy_in = '0; m_joy_st = '0; m_next_pop = 0;
            m_rdy = 1'b0; m_rel = 1'b0; m_ascii = '0; m_ovf = 1'b0; m_empty = 1'b1;
        end else begin
            logic pop, room;
            logic [8:0] h;
            logic [9:0] diff;
            int a, k;
            pop  = (mq.size() > 0) && (cyc >= m_next_pop);
            room = (mq.size() < DEPTH) || pop;
            m_rdy = 1'b0;
            if (pop) begin
                h = mq.pop_front();
                m_rdy = 1'b1; m_rel = h[8]; m_ascii = h[7:0];
                m_next_pop = cyc + GAP + 2;
            end
            if (d2v) begin
                if (room) mq.push_back(d2);
                else      m_ovf = 1'b1;
            end else begin
                diff = m_joy_in ^ m_joy_st;
                k = -1;
                for (int i = 9; i >= 0; i--) if (diff[i]) k = i;
                if (k >= 0 && room) begin
                    mq.push_back({~m_joy_in[k], (k == 9) ? 8'h30 : 8'(8'h31 + k)});
                    m_joy_st[k] = ~m_joy_st[k];
                end
            end
            d2v = d1v; d2 = d1;
            a = key_ascii(ps2_key[7:0]);
            d1v = m_primed && (ps2_key[10] != m_last) && (a >= 0);
            d1  = {~ps2_key[9], 8'(a)};
            m_last = ps2_key[10]; m_primed = 1'b1;
            m_joy_in = joy;
            m_empty = (mq.size() == 0);
        end
    end

    int tests = 0;
    int fails = 0;
    logic [7:0] log_a[$];
    logic       log_r[$];
    int         log_c[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (rdy) begin
                log_a.push_back(ascii); log_r.push_back(rel); log_c.push_back(cyc);
            end
            check("outputs{rdy,ascii,rel,ovf,empty}", {rdy, ascii, rel, ovf, empty},
                  {m_rdy, m_ascii, m_rel, m_ovf, m_empty});
        end
    endtask

    logic tog = 1'b0;
    task automatic ps2_ev(input logic press, input logic [7:0] sc);
        tog = ~tog;
        ps2_key = {tog, press, 1'b0, sc};
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobes(input string name, input int target, input int budget);
        int n = 0;
        while (log_a.size() < target && n < budget) begin
            tick(1); n++;
        end
        check(name, log_a.size(), target);
    endtask

    initial begin
        int base, c0;
        logic [7:0] codes [12];
        logic [7:0] want [12];
        fork compare_loop(); join_none

        tick(3);
        check("reset_ready", rdy, 0);
        check("reset_ascii", ascii, 0);
        check("reset_empty", empty, 1);
        check("reset_ovf", ovf, 0);
        rst_n = 1'b1;
        tick(5);

        // Keyboard 'a' press, then release 2000 cycles later.
        base = log_a.size();
        ps2_ev(1'b1, 8'h1C); c0 = cyc;
        tick(2000);
        ps2_ev(1'b0, 8'h1C);
        wait_strobes("ps2_count", base + 2, 3000);
        if (log_a.size() >= base + 2) begin
            check("ps2_latency", log_c[base] - c0, 4);
            check("ps2_press_ascii", log_a[base], 8'h61);
            check("ps2_press_rel", log_r[base], 0);
            check("ps2_rel_ascii", log_a[base+1], 8'h61);
            check("ps2_rel_rel", log_r[base+1], 1);
        end
        tick(GAP + 10);

        // Unmapped code is dropped; the following Enter is delivered alone.
        base = log_a.size();
        ps2_ev(1'b1, 8'h76);
        tick(4);
        ps2_ev(1'b1, 8'h5A);
        wait_strobes("unmapped_first", base + 1, 100);
        tick(GAP + 100);
        check("unmapped_count", log_a.size(), base + 1);
        if (log_a.size() > base) check("enter_ascii", log_a[base], 8'h0A);
        check("unmapped_ovf", ovf, 0);

        // Buttons "1" and "0" together; held two samples so both presses land.
        base = log_a.size();
        joy = 10'b10_0000_0001; c0 = cyc;
        tick(2);
        joy = '0;
        wait_strobes("joy_count", base + 4, 6000);
        if (log_a.size() >= base + 4) begin
            check("joy_latency", log_c[base] - c0, 3);
            check("joy0", {log_r[base],   log_a[base]},   {1'b0, 8'h31});
            check("joy1", {log_r[base+1], log_a[base+1]}, {1'b0, 8'h30});
            check("joy2", {log_r[base+2], log_a[base+2]}, {1'b1, 8'h31});
            check("joy3", {log_r[base+3], log_a[base+3]}, {1'b1, 8'h30});
            for (int i = 1; i < 4; i++)
                check("joy_spacing", (log_c[base+i] - log_c[base+i-1]) >= GAP + 2, 1);
        end
        tick(GAP + 100);
        check("joy_quiet", log_a.size(), base + 4);

        // 12 keys three cycles apart: one in flight + DEPTH buffered, rest dropped.
        codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45, 8'h1C, 8'h32};
        want  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30, 8'h61, 8'h62};
        base = log_a.size();
        for (int i = 0; i < 12; i++) begin
            ps2_ev(1'b1, codes[i]);
            tick(3);
        end
        wait_strobes("ovf_count", base + DEPTH + 1, 12000);
        tick(GAP + 100);
        check("ovf_count_final", log_a.size(), base + DEPTH + 1);
        check("ovf_flag", ovf, 1);
        for (int i = 0; i < 9; i++)
            if (log_a.size() > base + i) check("ovf_order", log_a[base+i], want[i]);

        // Keyboard write and joystick write collide on the same edge.
        base = log_a.size();
        ps2_ev(1'b1, 8'h32);
        tick(1);
        joy = 10'b00_0000_0010;
        tick(5);
        joy = '0;
        wait_strobes("prio_count", base + 3, 5000);
        if (log_a.size() >= base + 3) begin
            check("prio0", {log_r[base],   log_a[base]},   {1'b0, 8'h62});
            check("prio1", {log_r[base+1], log_a[base+1]}, {1'b0, 8'h32});
            check("prio2", {log_r[base+2], log_a[base+2]}, {1'b1, 8'h32});
        end
        tick(GAP + 100);

        // Reset during GAP with five entries queued.
        for (int i = 0; i < 6; i++) begin
            ps2_ev(1'b1, codes[i]);
            tick(3);
        end
        tick(12);
        check("pre_reset_not_empty", empty, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", rdy, 0);
        check("rst_empty", empty, 1);
        check("rst_ovf", ovf, 0);
        tick(3);
        rst_n = 1'b1;
        base = log_a.size();
        tick(100);
        check("post_reset_quiet", log_a.size(), base);
        check("post_reset_empty", empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
